// File: rtl/pipelined_adder_tree.sv
// ---------------------------------------------------------------------------
// pipelined_adder_tree
//
// Sums ELEMENTS signed operands with a binary tree. Each tree level has one
// register stage. The final stage optionally clamps the full-precision sum to
// OUT_WIDTH bits. Every stage carries a valid bit. The whole pipe advances
// together whenever the output is free or is being consumed.
//
// Ports:
//   clk_in     clock
//   rst_in     asynchronous active-high reset; clears every stage
//   in_data    ELEMENTS packed signed operands, element i at [i*IN_WIDTH +: IN_WIDTH]
//   in_valid   in_data holds a vector
//   in_ready   a vector is accepted this cycle (same as the pipe advance enable)
//   out_data   signed sum, saturated when OUT_WIDTH < IN_WIDTH+LEVELS
//   out_sat    out_data was clamped
//   out_valid  out_data/out_sat hold a result
//   out_ready  downstream accepts the result
// ---------------------------------------------------------------------------
module pipelined_adder_tree #(
    parameter int ELEMENTS  = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = IN_WIDTH + ((ELEMENTS > 1) ? $clog2(ELEMENTS) : 0)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [ELEMENTS*IN_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int LEVELS = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 0;
    localparam int FULL_W = IN_WIDTH + LEVELS;
    // A single operand still gets one output register stage.
    localparam int STAGES = (LEVELS > 0) ? LEVELS : 1;

    logic                       en;
    logic [STAGES-1:0]          valid_reg;
    logic signed [FULL_W-1:0]   total;
    logic [OUT_WIDTH-1:0]       sat_data;
    logic                       sat_flag;
    logic [OUT_WIDTH-1:0]       out_data_reg;
    logic                       out_sat_reg;

    // The pipe only stalls when a result sits at the output and is refused.
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

    // Valid bits shift with the data; an idle input inserts a bubble.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_reg <= '0;
        end else if (en) begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    // Level 0 is the sign-extended inputs. Level gi holds ceil(ELEMENTS/2^gi)
    // nodes. Levels below LEVELS are registered. The last level stays
    // combinational and feeds the saturating output register, so that
    // register is the last tree stage.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : lvl
            localparam int CNT = (ELEMENTS + (1 << gi) - 1) >> gi;
            logic signed [FULL_W-1:0] val [0:CNT-1];

            if (gi == 0) begin : g_inputs
                for (gj = 0; gj < CNT; gj++) begin : g_ext
                    assign val[gj] = FULL_W'(signed'(in_data[gj*IN_WIDTH +: IN_WIDTH]));
                end
            end else begin : g_add
                localparam int PCNT = (ELEMENTS + (1 << (gi - 1)) - 1) >> (gi - 1);
                logic signed [FULL_W-1:0] sum [0:CNT-1];

                for (gj = 0; gj < CNT; gj++) begin : g_pair
                    if (2*gj + 1 < PCNT) begin : g_two
                        assign sum[gj] = lvl[gi-1].val[2*gj] + lvl[gi-1].val[2*gj+1];
                    end else begin : g_pass
                        // Odd count: the last operand rides through unchanged.
                        assign sum[gj] = lvl[gi-1].val[2*gj];
                    end
                end

                if (gi < LEVELS) begin : g_reg
                    always_ff @(posedge clk_in or posedge rst_in) begin
                        if (rst_in) begin
                            for (int j = 0; j < CNT; j++) begin
                                val[j] <= '0;
                            end
                        end else if (en) begin
                            for (int j = 0; j < CNT; j++) begin
                                val[j] <= sum[j];
                            end
                        end
                    end
                end else begin : g_last
                    for (gj = 0; gj < CNT; gj++) begin : g_wire
                        assign val[gj] = sum[gj];
                    end
                end
            end
        end
    endgenerate

    assign total = lvl[LEVELS].val[0];

    generate
        if (OUT_WIDTH == FULL_W) begin : g_full
            assign sat_data = total;
            assign sat_flag = 1'b0;
        end else begin : g_clamp
            localparam logic signed [FULL_W-1:0] SAT_MAX =
                {{(FULL_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [FULL_W-1:0] SAT_MIN =
                {{(FULL_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

            always_comb begin
                sat_data = total[OUT_WIDTH-1:0];
                sat_flag = 1'b0;
                if (total > SAT_MAX) begin
                    sat_data = SAT_MAX[OUT_WIDTH-1:0];
                    sat_flag = 1'b1;
                end else if (total < SAT_MIN) begin
                    sat_data = SAT_MIN[OUT_WIDTH-1:0];
                    sat_flag = 1'b1;
                end
            end
        end
    endgenerate

    // Holding on en=0 keeps out_data/out_sat stable during a stall.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_data_reg <= '0;
            out_sat_reg  <= 1'b0;
        end else if (en) begin
            out_data_reg <= sat_data;
            out_sat_reg  <= sat_flag;
        end
    end

endmodule

// File: doc/pipelined_adder_tree.md
PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 The block SHALL have parameter ELEMENTS, default 8: number of signed operands summed per vector, legal range 1..64.
REQ-002 The block SHALL have parameter IN_WIDTH, default 8: width of each signed operand, legal range 2..32.
REQ-003 The block SHALL have parameter OUT_WIDTH, default IN_WIDTH+LEVELS: output width, legal range 2..IN_WIDTH+LEVELS, where LEVELS = ceil(log2(ELEMENTS)) and LEVELS is 0 when ELEMENTS=1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high, with clock port clk_in and reset port rst_in.
REQ-005 Ports SHALL be:
- clk_in  input  1  clock
- rst_in  input  1  async active-high reset
- in_data  input  ELEMENTS*IN_WIDTH  packed signed operands, element i at bits [i*IN_WIDTH +: IN_WIDTH]
- in_valid  input  1  in_data holds a vector
- in_ready  output  1  block accepts a vector this cycle
- out_data  output  OUT_WIDTH  signed sum
- out_sat  output  1  out_data was clamped
- out_valid  output  1  out_data/out_sat hold a result
- out_ready  input  1  downstream accepts the result

Function
REQ-006 The block SHALL compute the exact signed sum of all ELEMENTS operands at full precision FULL_W = IN_WIDTH+LEVELS bits, with sign extension at every level; no intermediate overflow is permitted.
REQ-007 The tree SHALL add adjacent pairs per level; at a level with an odd operand count, the unpaired last operand SHALL pass through that level's register unchanged.
REQ-008 Each tree level SHALL have one register stage; when ELEMENTS=1, a single output register stage SHALL exist. Latency L = max(LEVELS,1) cycles from the accept edge to out_valid.
REQ-009 Each stage SHALL carry a valid bit alongside its data; out_valid SHALL equal the last stage's valid bit.
REQ-010 Pipeline advance enable SHALL be en = out_ready OR NOT out_valid; all stages shift together when en=1 and hold when en=0.
REQ-011 in_ready SHALL equal en (combinational from out_ready and out_valid); a vector is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-012 When en=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 1; bubbles are not collapsed.
REQ-013 While out_valid=1 and out_ready=0, out_data and out_sat SHALL remain stable.
REQ-014 If OUT_WIDTH = FULL_W, out_data SHALL be the full sum and out_sat SHALL be 0.
REQ-015 If OUT_WIDTH < FULL_W, the final stage SHALL saturate: sum > 2^(OUT_WIDTH-1)-1 gives max positive, sum < -2^(OUT_WIDTH-1) gives min negative, and out_sat=1 only for a clamped result.
REQ-016 Results SHALL leave the block in acceptance order with no loss or duplication under any out_ready pattern.
REQ-017 A continuous stream with out_ready held at 1 SHALL sustain one vector per cycle.

Reset
REQ-018 When rst_in is asserted, all stage valid bits SHALL clear immediately (asynchronously), including out_valid=0, and out_data=0, out_sat=0, and all stage data registers SHALL be 0.
REQ-019 Reset mid-operation SHALL discard all in-flight vectors; after release, no stale result SHALL appear, and in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-020 Default parameters, in_data of eight 1s, out_ready=1 -> out_data=8 and out_valid=1 exactly 3 cycles after accept, with out_sat=0.
REQ-021 ELEMENTS=8, IN_WIDTH=8, OUT_WIDTH=11, all operands -128 -> out_data=-1024; all operands 127 -> out_data=1016; out_sat=0 in both cases.
REQ-022 ELEMENTS=8, IN_WIDTH=8, OUT_WIDTH=8, all operands 127 -> out_data=127 and out_sat=1; all -128 -> out_data=-128 and out_sat=1; operands {10,-3,0,0,0,0,0,0} -> out_data=7 and out_sat=0.
REQ-023 ELEMENTS=5, operands {1,2,3,4,5} -> out_data=15 after latency 3; ELEMENTS=1, operand -7 -> out_data=-7 after latency 1.
REQ-024 Backpressure scenario: stream sums 1..6 with out_ready=0 for 5 cycles, then random out_ready -> in_ready drops after the pipe fills, out_data is stable while stalled, and the outputs are exactly 1,2,3,4,5,6 in order.
REQ-025 Reset mid-operation scenario: assert rst_in with 2 vectors in flight -> out_valid=0 at once, and neither in-flight vector appears after release.
